// File: rtl/countdown_mmss_if.sv
// rtl/countdown_mmss_if.sv - command and display bundle for the MM:SS countdown timer
interface countdown_mmss_if;
    logic       tick;
    logic       load;
    logic [7:0] load_min;
    logic [7:0] load_sec;
    logic       start;
    logic       pause;
    logic [3:0] sec_ones;
    logic [3:0] sec_tens;
    logic [3:0] min_ones;
    logic [3:0] min_tens;
    logic       running;
    logic       done;
    logic       bo;

    modport master (
        output tick, load, load_min, load_sec, start, pause,
        input  sec_ones, sec_tens, min_ones, min_tens, running, done, bo
    );

    modport slave (
        input  tick, load, load_min, load_sec, start, pause,
        output sec_ones, sec_tens, min_ones, min_tens, running, done, bo
    );
endinterface

// File: rtl/countdown_mmss.sv
// rtl/countdown_mmss.sv - BCD MM:SS countdown timer; COUNTDOWN_AUTORELOAD_EN reloads the preset on expiry
module countdown_mmss (
    input  logic             clk,
    input  logic             rst,
    countdown_mmss_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

    state_t      state_q, state_d;
    logic [15:0] dig_q, dig_d;        // {min_tens, min_ones, sec_tens, sec_ones}
    logic [15:0] preset_q, preset_d;
    logic        done_q, done_d;
    logic        bo_q, bo_d;

    logic [15:0] load_val;
    logic [15:0] dec_val;
    logic        sec_wrap;

    function automatic logic [3:0] clamp9(input logic [3:0] d);
        return (d > 4'd9) ? 4'd9 : d;
    endfunction

    function automatic logic [3:0] clamp5(input logic [3:0] d);
        return (d > 4'd5) ? 4'd5 : d;
    endfunction

    assign load_val = {clamp9(bus.load_min[7:4]), clamp9(bus.load_min[3:0]),
                       clamp5(bus.load_sec[7:4]), clamp9(bus.load_sec[3:0])};

    // Borrow chain: each digit only moves when every lower digit wrapped.
    always_comb begin
        logic b0, b1, b2;
        dec_val = dig_q;
        b0 = (dig_q[3:0] == 4'd0);
        b1 = b0 && (dig_q[7:4] == 4'd0);
        b2 = b1 && (dig_q[11:8] == 4'd0);
        dec_val[3:0] = b0 ? 4'd9 : dig_q[3:0] - 4'd1;
        if (b0) dec_val[7:4]   = (dig_q[7:4] == 4'd0) ? 4'd5 : dig_q[7:4] - 4'd1;
        if (b1) dec_val[11:8]  = (dig_q[11:8] == 4'd0) ? 4'd9 : dig_q[11:8] - 4'd1;
        if (b2) dec_val[15:12] = dig_q[15:12] - 4'd1;
        sec_wrap = b1;
    end

    always_comb begin
        state_d  = state_q;
        dig_d    = dig_q;
        preset_d = preset_q;
        done_d   = 1'b0;
        bo_d     = 1'b0;
        if (bus.load) begin
            preset_d = load_val;
            dig_d    = load_val;
            state_d  = IDLE;
        end else if (bus.pause) begin
            if (state_q == RUN) state_d = PAUSE;
        end else if (bus.start && (state_q != RUN)) begin
            case (state_q)
                IDLE, PAUSE: begin
                    if (dig_q != 16'h0000) begin
                        state_d = RUN;
                    end else begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end
                end
                DONE: begin
                    dig_d = preset_q;
                    if (preset_q != 16'h0000) state_d = RUN;
                end
                default: state_d = IDLE;
            endcase
        end else if (bus.tick && (state_q == RUN)) begin
            dig_d = dec_val;
            bo_d  = sec_wrap;
            if (dec_val == 16'h0000) begin
                done_d = 1'b1;
`ifdef COUNTDOWN_AUTORELOAD_EN
                if (preset_q != 16'h0000) begin
                    dig_d = preset_q;
                end else begin
                    state_d = DONE;
                end
`else
                state_d = DONE;
`endif
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            dig_q    <= 16'h0000;
            preset_q <= 16'h0000;
            done_q   <= 1'b0;
            bo_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            dig_q    <= dig_d;
            preset_q <= preset_d;
            done_q   <= done_d;
            bo_q     <= bo_d;
        end
    end

    assign bus.min_tens = dig_q[15:12];
    assign bus.min_ones = dig_q[11:8];
    assign bus.sec_tens = dig_q[7:4];
    assign bus.sec_ones = dig_q[3:0];
    assign bus.running  = (state_q == RUN);
    assign bus.done     = done_q;
    assign bus.bo       = bo_q;
endmodule

// File: tb/tb_countdown_mmss.sv
// tb/tb_countdown_mmss.sv - table-driven checks for countdown_mmss
module tb_countdown_mmss;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    countdown_mmss_if bus();
    countdown_mmss dut (.clk(clk), .rst(rst), .bus(bus));

`ifdef COUNTDOWN_AUTORELOAD_EN
    localparam logic AR = 1'b1;
`else
    localparam logic AR = 1'b0;
`endif
    localparam logic N = 1'b0;
    localparam logic Y = 1'b1;

    typedef struct {
        logic        tick, load, start, pause;
        logic [7:0]  lmin, lsec;
        logic [15:0] dig;
        logic        run, dn, bo;
    } vec_t;

    vec_t tbl_a[$];
    vec_t tbl_b[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   step_no = 0;

    function automatic vec_t v(logic t, logic l, logic s, logic p, logic [7:0] mn, logic [7:0] sc,
                               logic [15:0] d, logic r, logic dn, logic b);
        vec_t x;
        x.tick = t; x.load = l; x.start = s; x.pause = p;
        x.lmin = mn; x.lsec = sc; x.dig = d; x.run = r; x.dn = dn; x.bo = b;
        return x;
    endfunction

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s step %0d: got %h expected %h", nm, step_no, act, exp);
        end
    endtask

    task automatic check_out(input logic [15:0] d, input logic r, input logic dn, input logic b);
        chk("digits", {bus.min_tens, bus.min_ones, bus.sec_tens, bus.sec_ones}, d);
        chk("run_done_bo", {13'd0, bus.running, bus.done, bus.bo}, {13'd0, r, dn, b});
    endtask

    task automatic apply(input vec_t x);
        bus.tick = x.tick; bus.load = x.load; bus.start = x.start; bus.pause = x.pause;
        bus.load_min = x.lmin; bus.load_sec = x.lsec;
        @(posedge clk);
        #1;
        step_no++;
        check_out(x.dig, x.run, x.dn, x.bo);
    endtask

    initial begin
        // Test 1 setup: 01:00, first tick borrows into minutes
        tbl_a.push_back(v(N,Y,N,N,8'h01,8'h00,16'h0100,N,N,N));
        tbl_a.push_back(v(N,N,Y,N,8'h00,8'h00,16'h0100,Y,N,N));
        tbl_a.push_back(v(Y,N,N,N,8'h00,8'h00,16'h0059,Y,N,Y));
        tbl_a.push_back(v(N,N,N,N,8'h00,8'h00,16'h0059,Y,N,N));
        // Test 2: pause freezes, resume and expire, then restart from preset
        tbl_b.push_back(v(N,Y,N,N,8'h00,8'h02,16'h0002,N,N,N));
        tbl_b.push_back(v(N,N,Y,N,8'h00,8'h00,16'h0002,Y,N,N));
        tbl_b.push_back(v(Y,N,N,N,8'h00,8'h00,16'h0001,Y,N,N));
        tbl_b.push_back(v(N,N,N,Y,8'h00,8'h00,16'h0001,N,N,N));
        for (int i = 0; i < 5; i++) tbl_b.push_back(v(Y,N,N,N,8'h00,8'h00,16'h0001,N,N,N));
        tbl_b.push_back(v(N,N,Y,N,8'h00,8'h00,16'h0001,Y,N,N));
        tbl_b.push_back(v(Y,N,N,N,8'h00,8'h00,AR ? 16'h0002 : 16'h0000,AR,Y,N));
        tbl_b.push_back(v(N,N,Y,N,8'h00,8'h00,16'h0002,Y,N,N));
        tbl_b.push_back(v(N,N,N,N,8'h00,8'h00,16'h0002,Y,N,N));
        // Minutes borrow 10:00 -> 09:59
        tbl_b.push_back(v(N,Y,N,N,8'h10,8'h00,16'h1000,N,N,N));
        tbl_b.push_back(v(N,N,Y,N,8'h00,8'h00,16'h1000,Y,N,N));
        tbl_b.push_back(v(Y,N,N,N,8'h00,8'h00,16'h0959,Y,N,Y));
        tbl_b.push_back(v(Y,N,N,N,8'h00,8'h00,16'h0958,Y,N,N));
        // Test 3: clamping and command priority
        tbl_b.push_back(v(N,Y,N,N,8'hAB,8'h7C,16'h9959,N,N,N));
        tbl_b.push_back(v(N,N,Y,Y,8'h00,8'h00,16'h9959,N,N,N));
        tbl_b.push_back(v(N,N,Y,N,8'h00,8'h00,16'h9959,Y,N,N));
        tbl_b.push_back(v(Y,N,N,N,8'h00,8'h00,16'h9958,Y,N,N));
        tbl_b.push_back(v(Y,Y,N,N,8'h12,8'h34,16'h1234,N,N,N));
        tbl_b.push_back(v(Y,N,Y,N,8'h00,8'h00,16'h1234,Y,N,N));
        tbl_b.push_back(v(Y,N,N,N,8'h00,8'h00,16'h1233,Y,N,N));
        tbl_b.push_back(v(Y,N,N,Y,8'h00,8'h00,16'h1233,N,N,N));
        // Test 4: zero preset
        tbl_b.push_back(v(N,Y,N,N,8'h00,8'h00,16'h0000,N,N,N));
        tbl_b.push_back(v(N,N,Y,N,8'h00,8'h00,16'h0000,N,Y,N));
        tbl_b.push_back(v(N,N,N,N,8'h00,8'h00,16'h0000,N,N,N));
        tbl_b.push_back(v(N,N,Y,N,8'h00,8'h00,16'h0000,N,N,N));
        tbl_b.push_back(v(Y,N,N,N,8'h00,8'h00,16'h0000,N,N,N));

        bus.tick = 1'b0; bus.load = 1'b0; bus.start = 1'b0; bus.pause = 1'b0;
        bus.load_min = 8'h00; bus.load_sec = 8'h00;
        #12;
        check_out(16'h0000, N, N, N);
        rst = 1'b0;

        foreach (tbl_a[i]) apply(tbl_a[i]);
        for (int i = 1; i <= 58; i++) begin
            logic [15:0] e;
            e = {8'h00, 4'((59 - i) / 10), 4'((59 - i) % 10)};
            apply(v(Y,N,N,N,8'h00,8'h00,e,Y,N,N));
        end
        apply(v(Y,N,N,N,8'h00,8'h00,AR ? 16'h0100 : 16'h0000,AR,Y,N));
        apply(v(N,N,N,N,8'h00,8'h00,AR ? 16'h0100 : 16'h0000,AR,N,N));

        foreach (tbl_b[i]) apply(tbl_b[i]);

        // Asynchronous reset mid-run at 12:34
        apply(v(N,Y,N,N,8'h12,8'h34,16'h1234,N,N,N));
        apply(v(N,N,Y,N,8'h00,8'h00,16'h1234,Y,N,N));
        bus.start = 1'b0;
        #2 rst = 1'b1;
        #1;
        step_no++;
        check_out(16'h0000, N, N, N);
        #1 rst = 1'b0;
        apply(v(Y,N,N,N,8'h00,8'h00,16'h0000,N,N,N));

`ifdef COUNTDOWN_AUTORELOAD_EN
        apply(v(N,Y,N,N,8'h00,8'h03,16'h0003,N,N,N));
        apply(v(N,N,Y,N,8'h00,8'h00,16'h0003,Y,N,N));
        for (int i = 1; i <= 6; i++) begin
            logic [15:0] e;
            e = {12'h000, 4'(3 - (i % 3))};
            apply(v(Y,N,N,N,8'h00,8'h00,e,Y,(i % 3) == 0,N));
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
